// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle main control unit:
// FSM states, decoded instruction classes, opcodes, ALU class codes, branch funct3.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_R,
    CLS_I,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_BNE
  } cls_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [3:0] ALUOP_IDLE   = 4'd0;
  localparam logic [3:0] ALUOP_ARITH  = 4'd1;
  localparam logic [3:0] ALUOP_BRANCH = 4'd2;
  localparam logic [3:0] ALUOP_ADDR   = 4'd3;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

endpackage

// File: rtl/ctrl_opdec.sv
// Combinational opcode classifier: maps opcode/funct3 to an instruction class
// and flags anything outside the supported RV32I subset as illegal.
module ctrl_opdec
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  output cls_t       o_cls,
  output logic       o_illegal
);

  always_comb begin
    o_cls     = CLS_NONE;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_R:  o_cls = CLS_R;
      OP_I:  o_cls = CLS_I;
      OP_LW: o_cls = CLS_LW;
      OP_SW: o_cls = CLS_SW;
      OP_BR: begin
        if (i_funct3 == F3_BEQ) begin
          o_cls = CLS_BEQ;
        end else if (i_funct3 == F3_BNE) begin
          o_cls = CLS_BNE;
        end else begin
          o_illegal = 1'b1;
        end
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle main control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) driving datapath enables
// and the ALU control interface. Define CTRL_ILLEGAL_TRAP_EN to halt on illegal instructions.
module control_fsm
  import ctrl_pkg::*;
#(
  parameter bit RESET_HALT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        zero,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic [3:0]  alu_op,
  output logic [3:0]  alu_funct,
  output logic        alu_src_b,
  output logic        mem_re,
  output logic        mem_we,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        illegal,
  output logic        halted
);

  state_t r_state;
  state_t w_next;
  cls_t   r_cls;
  cls_t   w_cls;
  logic   w_illegal;
  logic   w_taken;
  logic   w_unused_instr;

  assign w_unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  ctrl_opdec u_opdec (
    .i_opcode  (instr[6:0]),
    .i_funct3  (instr[14:12]),
    .o_cls     (w_cls),
    .o_illegal (w_illegal)
  );

  // Class is captured at DECODE so EXEC/MEM/WB see a stable value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RESET_HALT ? ST_HALT : ST_FETCH;
      r_cls   <= CLS_NONE;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) begin
        r_cls <= w_cls;
      end
    end
  end

  assign w_taken = ((r_cls == CLS_BEQ) && zero) || ((r_cls == CLS_BNE) && !zero);

  always_comb begin
    w_next    = r_state;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    alu_op    = ALUOP_IDLE;
    alu_funct = '0;
    alu_src_b = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;
    illegal   = 1'b0;
    halted    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (imem_ready) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          w_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_illegal) begin
          illegal = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
          w_next  = ST_HALT;
`else
          w_next  = ST_FETCH;
`endif
        end else begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Bit 30 only selects SUB/SRA for R-type; for I-type it is immediate data.
        alu_funct = {instr[30] & (r_cls == CLS_R), instr[14:12]};
        case (r_cls)
          CLS_R: begin
            alu_op = ALUOP_ARITH;
            w_next = ST_WB;
          end
          CLS_I: begin
            alu_op    = ALUOP_ARITH;
            alu_src_b = 1'b1;
            w_next    = ST_WB;
          end
          CLS_LW, CLS_SW: begin
            alu_op    = ALUOP_ADDR;
            alu_src_b = 1'b1;
            w_next    = ST_MEM;
          end
          CLS_BEQ, CLS_BNE: begin
            alu_op = ALUOP_BRANCH;
            pc_we  = w_taken;
            pc_src = w_taken;
            w_next = ST_FETCH;
          end
          default: w_next = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        mem_re = (r_cls == CLS_LW);
        mem_we = (r_cls == CLS_SW);
        if (dmem_ready) begin
          w_next = (r_cls == CLS_LW) ? ST_WB : ST_FETCH;
        end
      end
      ST_WB: begin
        reg_we = 1'b1;
        wb_sel = (r_cls == CLS_LW);
        w_next = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
        w_next = ST_HALT;
      end
      default: w_next = ST_FETCH;
    endcase
  end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle main control unit for the RV32I-subset core. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath enables. It is the producer side of the ALU control interface: it emits the 4-bit ALU class code and the masked funct bits that the ALU control decoder turns into an ALU operation.

## Interface
Parameters:
- `RESET_HALT`, default 0: when 1, the FSM leaves reset in HALT instead of FETCH (bench use only).

Ports:
- `clk`  in  1  core clock
- `reset`  in  1  reset; one clock, synchronous, active-high
- `instr`  in  32  instruction register contents, stable from DECODE onward
- `imem_ready`  in  1  instruction memory data valid this cycle
- `dmem_ready`  in  1  data memory access complete this cycle
- `zero`  in  1  ALU zero flag (EXEC cycle)
- `ir_we`  out  1  load instruction register
- `pc_we`  out  1  PC write enable
- `pc_src`  out  1  0 = PC+4, 1 = branch target
- `alu_op`  out  4  ALU class: 0 idle, 1 R/I arithmetic, 2 branch compare, 3 address add
- `alu_funct`  out  4  {instr[30] & is_R, instr[14:12]}
- `alu_src_b`  out  1  0 = rs2, 1 = immediate
- `mem_re`, `mem_we`  out  1 each  data memory read / write strobe
- `reg_we`  out  1  register file write
- `wb_sel`  out  1  0 = ALU result, 1 = load data
- `illegal`  out  1  one-cycle pulse on an unsupported instruction
- `halted`  out  1  FSM is in HALT

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. After reset the FSM is in FETCH and all outputs are 0.
- FETCH: waits for `imem_ready`. In the cycle it is high, assert `ir_we=1` and `pc_we=1` with `pc_src=0`, then go to DECODE.
- DECODE: classify `instr[6:0]`:
  - 0110011 R
  - 0010011 I-ALU
  - 0000011 LW
  - 0100011 SW
  - 1100011 BR, with funct3 000 BEQ or 001 BNE
  - Anything else, or BR with any other funct3, is illegal: pulse `illegal` and go to FETCH (see Configuration).
- EXEC:
  - R: `alu_op=1`, `alu_src_b=0`.
  - I-ALU: `alu_op=1`, `alu_src_b=1`.
  - LW/SW: `alu_op=3`, `alu_src_b=1`.
  - BR: `alu_op=2`, `alu_src_b=0`. The branch is taken when (BEQ & `zero`) or (BNE & !`zero`); if taken, `pc_we=1`, `pc_src=1`. BR then returns to FETCH.
  - R and I-ALU go to WB; LW and SW go to MEM.
- MEM: LW holds `mem_re`, SW holds `mem_we`, until `dmem_ready`. LW then goes to WB; SW goes to FETCH.
- WB: `reg_we=1`, with `wb_sel=1` for LW and 0 otherwise, then go to FETCH.
- `alu_funct[3]` is forced to 0 for every class except R. This keeps ADDI with immediate bit 10 set from decoding as SUB.
- `alu_op` and `alu_funct` are 0 outside EXEC.
- `reset` in any state wins: the next state is FETCH (or HALT when `RESET_HALT=1`) and the outputs are 0 in the following cycle.

## Timing
- Outputs are decoded from the registered state. `ir_we`, `pc_we`, `mem_re/mem_we` completion and branch `pc_we` also depend combinationally on `imem_ready`, `dmem_ready` and `zero` in the same cycle.
- Minimum latency with zero wait states, counted from the FETCH cycle to the next FETCH:
  - BR: 3 cycles
  - R, I-ALU, SW: 4 cycles
  - LW: 5 cycles
- Each cycle that a ready input is low adds exactly one cycle. There is no timeout.
- `imem_ready` or `dmem_ready` asserted outside its waiting state is ignored.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined: an illegal instruction pulses `illegal` and enters HALT. HALT holds `halted=1` with all enables 0 until `reset`.
- Macro not defined: `illegal` still pulses, but the instruction executes as a NOP (DECODE to FETCH). The HALT state is still reachable via `RESET_HALT`.

## Structure
- Package `ctrl_pkg` holds:
  - the state enum
  - opcode constants (OP_R, OP_I, OP_LW, OP_SW, OP_BR)
  - ALU class constants (ALUOP_IDLE=0, ALUOP_ARITH=1, ALUOP_BRANCH=2, ALUOP_ADDR=3)
  - funct3 constants F3_BEQ and F3_BNE
- Sub-module `ctrl_opdec` is combinational. It maps `instr` to a class and an illegal flag. The FSM registers the class in DECODE so it stays stable for EXEC, MEM and WB.

## Test plan
- `reset` held 2 cycles, then released with `imem_ready=1` and `instr`=ADD (0x002081B3) → `ir_we` in cycle 1, EXEC shows `alu_op=1`, `alu_funct=0x0`, WB shows `reg_we=1`, next FETCH in cycle 5.
- ADDI x1,x0,0x400 (0x40000093) → EXEC `alu_funct=0x0`, not 0x8; `alu_src_b=1`.
- BEQ with `zero=1`, then BNE with `zero=1` → first gives `pc_we=1`, `pc_src=1` in EXEC; second gives no `pc_we` in EXEC; each returns to FETCH after 3 cycles.
- LW with `dmem_ready` low for 3 cycles → `mem_re` high for 4 cycles, then WB with `wb_sel=1`; total 8 cycles.
- Opcode 0x7F with `CTRL_ILLEGAL_TRAP_EN` → one-cycle `illegal`, then `halted=1` stays high until `reset`. Without the macro → `illegal` pulses and FETCH follows.
- `reset` asserted during MEM of a SW → `mem_we=0` next cycle, FSM in FETCH, `pc_we` not asserted.
